// File: rtl/demux1hot_stage.sv
// demux1hot_stage: registered one-hot demultiplexer with a single-entry
// pipeline register between one valid/ready producer and OUTPUTS consumers.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_valid/ready    producer handshake; in_data payload, in_sel one-hot
//                     destination sampled with the payload
//   out_valid/ready   per-destination handshake (at most one valid bit set)
//   out_data          payload shared by every destination
//   err               one-cycle pulse after a malformed select is accepted
//   err_sticky        set by any err pulse, cleared only by rst
//   dlv_cnt           per-output delivery counters, output i at
//                     [i*CNT_WIDTH +: CNT_WIDTH]
//
// Optional: define DEMUX1HOT_DLV_CNT_EN to build saturating delivery
// counters; otherwise dlv_cnt is tied to zero and no counter flops exist.

module demux1hot_stage #(
  parameter int OUTPUTS   = 2,
  parameter int WIDTH     = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  input  logic [OUTPUTS-1:0]             in_sel,
  output logic [OUTPUTS-1:0]             out_valid,
  input  logic [OUTPUTS-1:0]             out_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic                           err,
  output logic                           err_sticky,
  output logic [OUTPUTS*CNT_WIDTH-1:0]   dlv_cnt
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t             state;
  logic [OUTPUTS-1:0] sel_q;
  logic [WIDTH-1:0]   data_q;
  logic               sel_ok;
  logic               deliver;
  logic               accept;

  assign sel_ok  = ($countones(in_sel) == 1);

  // Only the ready bit picked by the held select can complete a delivery.
  assign deliver = (state == FULL) && (|(sel_q & out_ready));
  assign in_ready = (state == EMPTY) || deliver;
  assign accept   = in_valid && in_ready;

  // sel_q is cleared whenever the stage empties, so it doubles as out_valid.
  assign out_valid = sel_q;
  assign out_data  = data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      sel_q      <= '0;
      data_q     <= '0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      err <= accept && !sel_ok;
      if (accept && !sel_ok) begin
        err_sticky <= 1'b1;
      end
      // A malformed accept is dropped, so it falls through to the
      // deliver/hold branches exactly as if no item had arrived.
      if (accept && sel_ok) begin
        state  <= FULL;
        sel_q  <= in_sel;
        data_q <= in_data;
      end else if (deliver) begin
        state <= EMPTY;
        sel_q <= '0;
      end
    end
  end

`ifdef DEMUX1HOT_DLV_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q [OUTPUTS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OUTPUTS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < OUTPUTS; i++) begin
        if (deliver && sel_q[i] && !(&cnt_q[i])) begin
          cnt_q[i] <= cnt_q[i] + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  for (genvar g = 0; g < OUTPUTS; g++) begin : g_cnt
    assign dlv_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end
`else
  assign dlv_cnt = '0;
`endif

endmodule

// File: tb/tb_demux1hot_stage.sv
// tb_demux1hot_stage: randomized and directed bench for demux1hot_stage
// against a slot-level reference model (destination index, payload, counts).

module tb_demux1hot_stage;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 2;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [N-1:0]  in_sel;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready;
  logic [W-1:0]  out_data;
  logic          err;
  logic          err_sticky;
  logic [N*CW-1:0] dlv_cnt;

  demux1hot_stage #(.OUTPUTS(N), .WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data),
    .err(err), .err_sticky(err_sticky),
    .dlv_cnt(dlv_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int bad  = 0;

  // Reference model: is an item held, which output it goes to, its payload,
  // the error flags and a plain count of deliveries per output.
  bit         m_full;
  int         m_dst;
  logic [W-1:0] m_data;
  bit         m_err;
  bit         m_sticky;
  int         m_cnt [N];

  function automatic int ones(logic [N-1:0] v);
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic int first_set(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [N-1:0] exp_valid();
    logic [N-1:0] v = '0;
    if (m_full) v[m_dst] = 1'b1;
    return v;
  endfunction

  function automatic logic exp_ready();
    return !m_full || out_ready[m_dst];
  endfunction

  function automatic logic [N*CW-1:0] exp_cnt();
    logic [N*CW-1:0] v = '0;
`ifdef DEMUX1HOT_DLV_CNT_EN
    int top = (1 << CW) - 1;
    for (int i = 0; i < N; i++)
      v[i*CW +: CW] = CW'((m_cnt[i] > top) ? top : m_cnt[i]);
`endif
    return v;
  endfunction

  task automatic model_reset();
    m_full = 0; m_dst = 0; m_data = '0;
    m_err = 0; m_sticky = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  task automatic drive(input logic v, input logic [N-1:0] s,
                       input logic [W-1:0] d, input logic [N-1:0] r);
    in_valid = v; in_sel = s; in_data = d; out_ready = r;
  endtask

  // Advance one clock: evaluate the handshake on the values the DUT sees
  // at the edge, then update the model.
  task automatic step();
    bit dl, rd, ac, gd;
    dl = m_full && out_ready[m_dst];
    rd = !m_full || dl;
    ac = in_valid && rd;
    gd = (ones(in_sel) == 1);
    @(posedge clk);
    if (dl) m_cnt[m_dst]++;
    if (ac && gd) begin
      m_full = 1; m_dst = first_set(in_sel); m_data = in_data;
    end else if (dl) begin
      m_full = 0;
    end
    m_err = ac && !gd;
    if (m_err) m_sticky = 1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, '0, '0);
    model_reset();
    #12 rst = 1'b0;
    #1;
    vecs++;
    if (in_ready !== 1'b1 || out_valid !== '0 || out_data !== '0) begin
      bad++;
      $display("FAIL reset.outputs got rdy=%b vld=%b dat=%h want 1 0 00",
               in_ready, out_valid, out_data);
    end
    vecs++;
    if (err !== 1'b0 || err_sticky !== 1'b0 || dlv_cnt !== '0) begin
      bad++;
      $display("FAIL reset.flags got err=%b stk=%b cnt=%h want 0 0 0",
               err, err_sticky, dlv_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    drive(1'b1, 4'b0100, 8'hA5, 4'b0100);
    #1;
    vecs++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL single.in_ready0 got %b want 1", in_ready);
    end
    step();
    drive(1'b0, '0, '0, 4'b0100);
    #1;
    vecs++;
    if (out_valid !== 4'b0100 || out_data !== 8'hA5 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL single.out got vld=%b dat=%h rdy=%b want 0100 a5 1",
               out_valid, out_data, in_ready);
    end
    step();
    vecs++;
    if (out_valid !== '0 || dlv_cnt !== exp_cnt()) begin
      bad++;
      $display("FAIL single.after got vld=%b cnt=%h want 0000 %h",
               out_valid, dlv_cnt, exp_cnt());
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d;
    logic [N-1:0] s;
    for (int i = 0; i <= 8; i++) begin
      d = W'($urandom);
      s = N'(1 << (i % N));
      if (i < 8) drive(1'b1, s, d, 4'b1111);
      else drive(1'b0, '0, '0, 4'b1111);
      #1;
      vecs++;
      if (in_ready !== 1'b1 || out_valid !== exp_valid()
          || (m_full && out_data !== m_data)) begin
        bad++;
        $display("FAIL b2b[%0d] got rdy=%b vld=%b dat=%h want 1 %b %h",
                 i, in_ready, out_valid, out_data, exp_valid(), m_data);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 4'b0010, 8'h3C, 4'b0000);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b0001, W'($urandom), 4'b0000);
      #1;
      vecs++;
      if (out_valid !== 4'b0010 || out_data !== 8'h3C || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp.hold[%0d] got vld=%b dat=%h rdy=%b want 0010 3c 0",
                 i, out_valid, out_data, in_ready);
      end
      step();
    end
    drive(1'b0, '0, '0, 4'b1000);
    #1;
    vecs++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL bp.wrong_ready got rdy=%b want 0", in_ready);
    end
    step();
    drive(1'b0, '0, '0, 4'b0010);
    #1;
    vecs++;
    if (in_ready !== 1'b1 || out_valid !== 4'b0010) begin
      bad++;
      $display("FAIL bp.release got rdy=%b vld=%b want 1 0010",
               in_ready, out_valid);
    end
    step();
    vecs++;
    if (out_valid !== '0) begin
      bad++; $display("FAIL bp.empty got vld=%b want 0000", out_valid);
    end
  endtask

  task automatic test_malformed();
    logic [N-1:0] bad_sel [2];
    bad_sel[0] = 4'b0000;
    bad_sel[1] = 4'b0110;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, bad_sel[i], 8'hEE, 4'b1111);
      #1;
      vecs++;
      if (in_ready !== 1'b1) begin
        bad++; $display("FAIL mal.rdy[%0d] got %b want 1", i, in_ready);
      end
      step();
      drive(1'b0, '0, '0, 4'b1111);
      #1;
      vecs++;
      if (err !== 1'b1 || err_sticky !== 1'b1 || out_valid !== '0) begin
        bad++;
        $display("FAIL mal.err[%0d] got err=%b stk=%b vld=%b want 1 1 0000",
                 i, err, err_sticky, out_valid);
      end
      step();
      vecs++;
      if (err !== 1'b0 || err_sticky !== 1'b1) begin
        bad++;
        $display("FAIL mal.pulse[%0d] got err=%b stk=%b want 0 1",
                 i, err, err_sticky);
      end
    end
    drive(1'b1, 4'b1000, 8'h5A, 4'b1000);
    step();
    drive(1'b0, '0, '0, 4'b1000);
    #1;
    vecs++;
    if (out_valid !== 4'b1000 || out_data !== 8'h5A || err !== 1'b0) begin
      bad++;
      $display("FAIL mal.good got vld=%b dat=%h err=%b want 1000 5a 0",
               out_valid, out_data, err);
    end
    step();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 4'b0001, 8'h77, 4'b0000);
    step();
    drive(1'b0, '0, '0, 4'b0000);
    #2 rst = 1'b1;
    #1;
    model_reset();
    vecs++;
    if (out_valid !== '0) begin
      bad++; $display("FAIL rmid.async got vld=%b want 0000", out_valid);
    end
    #1 rst = 1'b0;
    #1;
    vecs++;
    if (in_ready !== 1'b1 || err_sticky !== 1'b0 || dlv_cnt !== '0
        || out_valid !== '0) begin
      bad++;
      $display("FAIL rmid.after got rdy=%b stk=%b cnt=%h vld=%b want 1 0 0 0",
               in_ready, err_sticky, dlv_cnt, out_valid);
    end
    @(posedge clk); #1;
    vecs++;
    if (out_valid !== '0) begin
      bad++; $display("FAIL rmid.glitch got vld=%b want 0000", out_valid);
    end
  endtask

  task automatic test_saturation();
    int want [5];
    want[0] = 1; want[1] = 2; want[2] = 3; want[3] = 3; want[4] = 3;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b0001, W'(i), 4'b0001);
      step();
      drive(1'b0, '0, '0, 4'b0001);
      step();
      vecs++;
`ifdef DEMUX1HOT_DLV_CNT_EN
      if (int'(dlv_cnt[0 +: CW]) != want[i]) begin
        bad++;
        $display("FAIL sat[%0d] got %0d want %0d", i, dlv_cnt[0 +: CW], want[i]);
      end
`else
      if (dlv_cnt !== '0) begin
        bad++; $display("FAIL sat[%0d] got %h want 0", i, dlv_cnt);
      end
`endif
    end
  endtask

  task automatic test_random();
    logic [N-1:0] s;
    logic [31:0]  r;
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      if (r[2:0] == 3'd0) s = r[11:8];
      else s = N'(1 << r[5:4]);
      drive(r[12] | r[13], s, r[23:16], r[27:24]);
      #1;
      vecs++;
      if (in_ready !== exp_ready() || out_valid !== exp_valid()
          || (m_full && out_data !== m_data)
          || err !== m_err || err_sticky !== m_sticky
          || dlv_cnt !== exp_cnt()) begin
        bad++;
        $display("FAIL rand[%0d] got rdy=%b vld=%b dat=%h err=%b stk=%b cnt=%h want %b %b %h %b %b %h",
                 i, in_ready, out_valid, out_data, err, err_sticky, dlv_cnt,
                 exp_ready(), exp_valid(), m_data, m_err, m_sticky, exp_cnt());
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_malformed();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end

endmodule

// File: doc/demux1hot_stage.md
Name: demux1hot_stage

Overview:
- Registered one-hot demultiplexer. It is the distribution counterpart of the one-hot mux.
- Accepts one valid/ready stream with a one-hot destination select and delivers each item to exactly one of OUTPUTS valid/ready consumers.
- Single-entry pipeline register sits between producer and consumers. Sustains one transfer per cycle when the selected consumer is ready.
- Flags malformed selects (zero or multiple bits set).

Parameters:
- OUTPUTS, 2, number of destination ports (>=2)
- WIDTH, 1, data width in bits
- CNT_WIDTH, 16, width of per-output delivery counters (optional feature only)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  producer has an item
- in_ready  output  1  stage accepts item this cycle
- in_data  input  WIDTH  item payload
- in_sel  input  OUTPUTS  one-hot destination select, sampled with in_data
- out_valid  output  OUTPUTS  per-destination valid; at most one bit set
- out_ready  input  OUTPUTS  per-destination ready
- out_data  output  WIDTH  payload, shared by all destinations
- err  output  1  one-cycle pulse: malformed select accepted
- err_sticky  output  1  set by any err pulse, cleared only by rst
- dlv_cnt  output  OUTPUTS*CNT_WIDTH  per-output delivery counts, output i at [i*CNT_WIDTH +: CNT_WIDTH]

Behaviour:
- Reset (async, rst=1):
  - State EMPTY.
  - out_valid=0, out_data=0, internal sel register=0.
  - err=0, err_sticky=0, dlv_cnt=0.
  - in_ready=1 as soon as rst deasserts.
  - Assertion mid-transfer discards the held item; no out_valid glitch after release.
- Terms:
  - Accept = in_valid & in_ready at a rising edge.
  - Deliver = |(out_valid & out_ready).
- States:
  - EMPTY: in_ready=1, out_valid=0.
  - FULL: out_valid = sel_q; out_data = data_q.
- in_ready = EMPTY | (FULL & out_ready selected by sel_q). This is a combinational pass of the single selected ready bit. The path out_ready->in_ready is allowed.
- Transitions:
  - EMPTY + accept(good sel) -> FULL; capture in_data and in_sel.
  - FULL + deliver + no accept -> EMPTY.
  - FULL + deliver + accept(good sel) -> FULL; new item replaces the old one in the same edge. No bubble, so throughput is 1/cycle.
  - FULL + no deliver -> FULL; data_q and sel_q stable; in_ready=0.
- Latency: item accepted at edge N is visible on out_valid/out_data after edge N. One cycle.
- Malformed select (in_sel == 0 or popcount > 1) on accept:
  - Item is consumed (producer not stalled) and dropped.
  - err=1 for the following cycle; err_sticky set.
  - State after the edge: EMPTY if the old item was delivered or the stage was empty, otherwise unchanged FULL.
- A well-formed accept sets err=0 next cycle. err is registered.
- out_ready bits of non-selected outputs are ignored.
- out_valid never drops without a deliver (standard valid/ready: no retraction).
- in_data and in_sel are don't-care when in_valid=0; they must not affect state.

Optional Feature:
- Macro: DEMUX1HOT_DLV_CNT_EN.
- Defined: one CNT_WIDTH counter per output. It increments on each deliver to that output and saturates at all-ones, with no wrap. Reset to 0 by rst.
- Not defined: dlv_cnt is driven constant 0 and no counter flops are built. All other behaviour is identical.

Test Plan:
- Reset then single item: rst pulse; in_valid=1, in_sel=4'b0100, in_data=0xA5, out_ready=4'b0100 -> out_valid=4'b0100, out_data=0xA5 one cycle later; in_ready=1 throughout; dlv_cnt[2]=1 with macro.
- Back-to-back streaming: 8 items, sel cycling 0001/0010/0100/1000, all out_ready=1 -> 8 deliveries in 8 consecutive cycles in order, no bubble.
- Backpressure: item to sel=0010 with out_ready=0000 for 5 cycles -> out_valid=0010 and out_data stable, in_ready=0. Raising out_ready[1] -> deliver, in_ready=1 the same cycle. out_ready[3]=1 alone never delivers.
- Malformed sel: accept with in_sel=0000, then 0110 -> each consumed, nothing delivered, err pulses once per item, err_sticky=1 until rst; a following good item is delivered normally.
- Reset mid-operation: FULL with out_ready=0, assert rst asynchronously mid-cycle -> out_valid=0 immediately; after release the stage is EMPTY and counters/err_sticky are 0.
- Counter saturation (macro, CNT_WIDTH=2): 5 deliveries to output 0 -> dlv_cnt[0] reads 1,2,3,3,3.
